// File: rtl/alu_operand_stage_if.sv
// Handshake, forwarding and operand bus between decode, the operand stage and the ALU.
// The slave view belongs to the operand stage; the master view belongs to its surroundings.
interface alu_operand_stage_if #(
    parameter int WIDTH       = 32,
    parameter int STALL_CNT_W = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [4:0]             in_rs1_addr;
    logic [4:0]             in_rs2_addr;
    logic [4:0]             in_rd_addr;
    logic [WIDTH-1:0]       in_rs1_data;
    logic [WIDTH-1:0]       in_rs2_data;
    logic [WIDTH-1:0]       in_imm;
    logic                   in_use_imm;
    logic [2:0]             in_op;
    logic                   flush;
    logic                   ex_wr_en;
    logic [4:0]             ex_rd_addr;
    logic [WIDTH-1:0]       ex_result;
    logic                   wb_wr_en;
    logic [4:0]             wb_rd_addr;
    logic [WIDTH-1:0]       wb_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       reg1;
    logic [WIDTH-1:0]       reg2;
    logic [2:0]             op;
    logic [4:0]             out_rd_addr;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport slave (
        input  in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rs1_data, in_rs2_data,
               in_imm, in_use_imm, in_op, flush,
               ex_wr_en, ex_rd_addr, ex_result, wb_wr_en, wb_rd_addr, wb_data, out_ready,
        output in_ready, out_valid, reg1, reg2, op, out_rd_addr, stall_cycles
    );

    modport master (
        output in_valid, in_rs1_addr, in_rs2_addr, in_rd_addr, in_rs1_data, in_rs2_data,
               in_imm, in_use_imm, in_op, flush,
               ex_wr_en, ex_rd_addr, ex_result, wb_wr_en, wb_rd_addr, wb_data, out_ready,
        input  in_ready, out_valid, reg1, reg2, op, out_rd_addr, stall_cycles
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Single-entry operand register in front of the ALU: selects forwarded/immediate operands at
// capture, refreshes held operands from writeback while stalled, and counts stall cycles.
module alu_operand_stage #(
    parameter int WIDTH       = 32,
    parameter int STALL_CNT_W = 16
) (
    input logic                clk,
    input logic                reset,
    alu_operand_stage_if.slave bus
);
    logic                   valid_q;
    logic [WIDTH-1:0]       reg1_q;
    logic [WIDTH-1:0]       reg2_q;
    logic [2:0]             op_q;
    logic [4:0]             rd_q;
    logic [4:0]             rs1_q;
    logic [4:0]             rs2_q;
    logic                   use_imm_q;
    logic [STALL_CNT_W-1:0] stall_q;

    logic                   in_ready;
    logic                   capture;
    logic                   hold;
    logic                   snoop1;
    logic                   snoop2;
    logic [WIDTH-1:0]       src1;
    logic [WIDTH-1:0]       src2;

    // Register 0 reads as zero and is never forwarded; ex beats wb because it is younger.
    function automatic logic [WIDTH-1:0] fwd(
        input logic [4:0]       addr,
        input logic [WIDTH-1:0] rf_data,
        input logic             ex_en,
        input logic [4:0]       ex_rd,
        input logic [WIDTH-1:0] ex_res,
        input logic             wb_en,
        input logic [4:0]       wb_rd,
        input logic [WIDTH-1:0] wb_d
    );
        if (addr == 5'd0)
            return '0;
        else if (ex_en && ex_rd == addr)
            return ex_res;
        else if (wb_en && wb_rd == addr)
            return wb_d;
        else
            return rf_data;
    endfunction

    always_comb begin
        src1 = fwd(bus.in_rs1_addr, bus.in_rs1_data, bus.ex_wr_en, bus.ex_rd_addr, bus.ex_result,
                   bus.wb_wr_en, bus.wb_rd_addr, bus.wb_data);
        src2 = fwd(bus.in_rs2_addr, bus.in_rs2_data, bus.ex_wr_en, bus.ex_rd_addr, bus.ex_result,
                   bus.wb_wr_en, bus.wb_rd_addr, bus.wb_data);
        if (bus.in_use_imm)
            src2 = bus.in_imm;
    end

    assign in_ready = (!valid_q || bus.out_ready) && !bus.flush && !reset;
    assign capture  = bus.in_valid && in_ready;
    assign hold     = valid_q && !bus.out_ready;

    // Only writeback is snooped while holding: the ex result of a stalled pipe is not final.
    assign snoop1 = hold && !bus.flush && bus.wb_wr_en && bus.wb_rd_addr != 5'd0
                    && bus.wb_rd_addr == rs1_q;
    assign snoop2 = hold && !bus.flush && bus.wb_wr_en && bus.wb_rd_addr != 5'd0
                    && bus.wb_rd_addr == rs2_q && !use_imm_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            reg1_q    <= '0;
            reg2_q    <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_imm_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            if (hold && stall_q != '1)
                stall_q <= stall_q + STALL_CNT_W'(1);

            if (bus.flush) begin
                valid_q <= 1'b0;
            end else if (capture) begin
                valid_q   <= 1'b1;
                reg1_q    <= src1;
                reg2_q    <= src2;
                op_q      <= bus.in_op;
                rd_q      <= bus.in_rd_addr;
                rs1_q     <= bus.in_rs1_addr;
                rs2_q     <= bus.in_rs2_addr;
                use_imm_q <= bus.in_use_imm;
            end else begin
                if (valid_q && bus.out_ready)
                    valid_q <= 1'b0;
                if (snoop1)
                    reg1_q <= bus.wb_data;
                if (snoop2)
                    reg2_q <= bus.wb_data;
            end
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = valid_q;
    assign bus.reg1         = reg1_q;
    assign bus.reg2         = reg2_q;
    assign bus.op           = op_q;
    assign bus.out_rd_addr  = rd_q;
    assign bus.stall_cycles = stall_q;
endmodule
